// File: rtl/iir_lpf_mc.sv
// iir_lpf_mc: multichannel cascaded 1st-order IIR low-pass, one shared 18x18 multiplier.
// Define IIR_LPF_MC_SAT_EN to saturate each stage result instead of wrapping.
module iir_lpf_mc #(
   parameter int CHANNELS = 2,
   parameter int STAGES   = 1,
   parameter int A2_DEF   = -32440,
   parameter int B_DEF    = 164
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [9:0]             div,
   input  logic [16*CHANNELS-1:0] in,
   input  logic                   coef_we,
   input  logic [1:0]             coef_stage,
   input  logic [1:0]             coef_sel,
   input  logic [17:0]            coef_data,
   input  logic                   overrun_clr,
   output logic [16*CHANNELS-1:0] out,
   output logic                   out_valid,
   output logic                   overrun
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam logic signed [17:0] BD = 18'(B_DEF);
   localparam logic signed [17:0] AD = 18'(A2_DEF);

   typedef enum logic [2:0] {IDLE, MUL_B1, MUL_B2, MUL_A2, STORE} state_t;
   state_t state, nstate;

   logic [9:0] cnt;
   logic strobe, accept, drop, last_ch, last_stg;
   logic [CW-1:0] ch;
   logic [SW-1:0] stg;
   logic signed [17:0] sh_b1 [STAGES];
   logic signed [17:0] sh_b2 [STAGES];
   logic signed [17:0] sh_a2 [STAGES];
   logic signed [17:0] ac_b1 [STAGES];
   logic signed [17:0] ac_b2 [STAGES];
   logic signed [17:0] ac_a2 [STAGES];
   logic signed [17:0] nb1 [STAGES];
   logic signed [17:0] nb2 [STAGES];
   logic signed [17:0] na2 [STAGES];
   logic signed [15:0] xp [CHANNELS][STAGES];
   logic signed [15:0] yp [CHANNELS][STAGES];
   logic [16*CHANNELS-1:0] samp, outs, outs_n;
   logic signed [15:0] sy, xcur, ycur;
   logic signed [17:0] ma, mb;
   logic signed [35:0] prod;
   logic signed [39:0] acc;

   assign strobe   = (div != 10'd0) && (cnt >= div - 10'd1);
   assign last_ch  = (ch == CW'(CHANNELS - 1));
   assign last_stg = (stg == SW'(STAGES - 1));

   // sample-rate divider; >= makes a shrunk div wrap on the next clock
   always_ff @(posedge clk) begin
      if (reset || div == 10'd0) cnt <= '0;
      else if (strobe)           cnt <= '0;
      else                       cnt <= cnt + 10'd1;
   end

   // sequencer state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nstate;
   end

   // next state, plus strobe accept/drop decode
   always_comb begin
      nstate = state;
      accept = 1'b0;
      drop   = 1'b0;
      unique case (state)
         IDLE: begin
            accept = strobe;
            if (strobe) nstate = MUL_B1;
         end
         MUL_B1:  nstate = MUL_B2;
         MUL_B2:  nstate = MUL_A2;
         MUL_A2:  nstate = STORE;
         STORE:   nstate = (last_ch && last_stg) ? IDLE : MUL_B1;
         default: nstate = IDLE;
      endcase
      if (state != IDLE) drop = strobe;
   end

   // (channel, stage) position, channel-major order
   always_ff @(posedge clk) begin
      if (reset || accept) begin
         ch  <= '0;
         stg <= '0;
      end else if (state == STORE) begin
         if (last_stg) begin
            stg <= '0;
            ch  <= last_ch ? '0 : ch + 1'b1;
         end else begin
            stg <= stg + 1'b1;
         end
      end
   end

   // shadow bank with this cycle's write folded in, so a same-cycle commit sees it
   always_comb begin
      for (int s = 0; s < STAGES; s++) begin
         nb1[s] = sh_b1[s];
         nb2[s] = sh_b2[s];
         na2[s] = sh_a2[s];
         if (coef_we && int'(coef_stage) == s) begin
            case (coef_sel)
               2'd0:    nb1[s] = coef_data;
               2'd1:    nb2[s] = coef_data;
               2'd2:    na2[s] = coef_data;
               default: ;
            endcase
         end
      end
   end

   // shadow bank always tracks writes; active bank only moves at sample commit
   always_ff @(posedge clk) begin
      for (int s = 0; s < STAGES; s++) begin
         if (reset) begin
            sh_b1[s] <= BD;
            sh_b2[s] <= BD;
            sh_a2[s] <= AD;
            ac_b1[s] <= BD;
            ac_b2[s] <= BD;
            ac_a2[s] <= AD;
         end else begin
            sh_b1[s] <= nb1[s];
            sh_b2[s] <= nb2[s];
            sh_a2[s] <= na2[s];
            if (accept) begin
               ac_b1[s] <= nb1[s];
               ac_b2[s] <= nb2[s];
               ac_a2[s] <= na2[s];
            end
         end
      end
   end

   assign xcur = (stg == '0) ? $signed(samp[{ch, 4'b0} +: 16]) : sy;

   // operand select for the shared multiplier
   always_comb begin
      ma = '0;
      mb = '0;
      unique case (state)
         MUL_B1: begin
            ma = ac_b1[stg];
            mb = {{2{xcur[15]}}, xcur};
         end
         MUL_B2: begin
            ma = ac_b2[stg];
            mb = {{2{xp[ch][stg][15]}}, xp[ch][stg]};
         end
         MUL_A2: begin
            ma = ac_a2[stg];
            mb = {{2{yp[ch][stg][15]}}, yp[ch][stg]};
         end
         default: ;
      endcase
   end

   assign prod = ma * mb;

`ifdef IIR_LPF_MC_SAT_EN
   // clamp when acc>>>15 does not fit in 16 bits
   always_comb begin
      if (acc[39:30] == {10{acc[39]}}) ycur = acc[30:15];
      else                             ycur = acc[39] ? 16'sh8000 : 16'sh7fff;
   end
`else
   assign ycur = acc[30:15];
`endif

   // staging copy of out with the current channel's final result inserted
   always_comb begin
      outs_n = outs;
      outs_n[{ch, 4'b0} +: 16] = ycur;
   end

   // accumulate, then store stage history and publish all channels together
   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         sy        <= '0;
         samp      <= '0;
         outs      <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            for (int s = 0; s < STAGES; s++) begin
               xp[c][s] <= '0;
               yp[c][s] <= '0;
            end
         end
      end else begin
         out_valid <= 1'b0;
         if (accept) samp <= in;
         unique case (state)
            MUL_B1: acc <= {{4{prod[35]}}, prod};
            MUL_B2: acc <= acc + {{4{prod[35]}}, prod};
            MUL_A2: acc <= acc - {{4{prod[35]}}, prod};
            STORE: begin
               xp[ch][stg] <= xcur;
               yp[ch][stg] <= ycur;
               sy          <= ycur;
               if (last_stg) begin
                  outs <= outs_n;
                  if (last_ch) begin
                     out       <= outs_n;
                     out_valid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // sticky overrun; a drop wins over a same-cycle clear
   always_ff @(posedge clk) begin
      if (reset)            overrun <= 1'b0;
      else if (drop)        overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
   end

endmodule
